sia_txarb: RTL and testbench

Round-robin arbiter that shares one SIA transmit queue between NREQ independent requesters (e.g. console, debug monitor, DMA channel).
- A requester that wins the grant is locked to the queue until it pushes a word flagged last, so packets never interleave on the wire.
- A watchdog releases the lock if the holder stalls mid-packet.
- Sits between the requesters and the transmit queue's dat_i/we_i/not_full_o ports.

---
 rtl/sia_pkg.sv | 24 ++
 rtl/sia_rr_pick.sv | 45 ++++
 rtl/sia_txarb.sv | 139 +++++++++++++
 tb/tb_sia_txarb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sia_pkg.sv
// Shared definitions for the SIA transmit-side arbitration blocks.
// Contents:
//   state_t  - arbiter FSM states (ST_IDLE, ST_LOCKED)
//   MAX_REQ  - largest supported requester count
//   IDX_BITS - width of a requester index / priority pointer
//   onehot() - index -> one-hot decode over MAX_REQ bits
package sia_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned IDX_BITS = 3;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_BITS-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sia_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req upward starting at ptr+1 (wrapping) and returns the first set bit.
// Ports:
//   req   in  N         request vector
//   ptr   in  IDX_BITS  index of the last winner (lowest priority this round)
//   gnt   out N         one-hot winner, zero when no request
//   idx   out IDX_BITS  index of the winner (0 when no request)
//   valid out 1         at least one request present
module sia_rr_pick
  import sia_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  logic [MAX_REQ-1:0]  req_pad;
  logic [MAX_REQ-1:0]  oh;
  logic [IDX_BITS-1:0] cand;
  logic [IDX_BITS-1:0] win;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    cand           = '0;
    win            = '0;
    valid          = 1'b0;
    // Candidates visited in priority order: ptr+1, ptr+2, ..., ptr (mod N).
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_BITS'((32'(ptr) + i) % N);
      if (!valid && req_pad[cand]) begin
        valid = 1'b1;
        win   = cand;
      end
    end
    oh    = onehot(win);
    gnt   = valid ? oh[N-1:0] : '0;
    idx   = win;
  end

endmodule

// File: rtl/sia_txarb.sv
// Round-robin arbiter sharing one SIA transmit queue between NREQ requesters.
// A winner stays locked to the queue until it pushes a word flagged last, so
// packets never interleave; a watchdog drops the lock if the holder stalls.
// Ports:
//   clk_i          in  1               system clock
//   reset_i        in  1               synchronous active-high reset
//   req_i          in  NREQ            per-requester word valid
//   last_i         in  NREQ            per-requester end of packet (with req_i)
//   dat_i          in  NREQ*DATA_BITS  packed data, requester k at [k*DATA_BITS +: DATA_BITS]
//   ack_o          out NREQ            word accepted this cycle
//   gnt_o          out NREQ            registered one-hot grant
//   txq_dat_o      out DATA_BITS       data to the queue
//   txq_we_o       out 1               push strobe to the queue
//   txq_not_full_i in  1               queue has room
//   abort_o        out 1               one-cycle pulse on watchdog release
//   busy_o         out 1               a requester holds the lock
module sia_txarb
  import sia_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned TIMEOUT_BITS = 8,
  parameter int unsigned TIMEOUT      = 200
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           last_i,
  input  logic [NREQ*DATA_BITS-1:0] dat_i,
  output logic [NREQ-1:0]           ack_o,
  output logic [NREQ-1:0]           gnt_o,
  output logic [DATA_BITS-1:0]      txq_dat_o,
  output logic                      txq_we_o,
  input  logic                      txq_not_full_i,
  output logic                      abort_o,
  output logic                      busy_o
);

  localparam logic [IDX_BITS-1:0]     PTR_RST = IDX_BITS'(NREQ - 1);
  localparam bit                      WD_EN   = (TIMEOUT != 0);
  // Expiry is detected on the idle cycle that would bring the count to TIMEOUT,
  // so release and the abort pulse land together on the following edge.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

  state_t                  state_q;
  logic [NREQ-1:0]         gnt_q;
  logic [IDX_BITS-1:0]     ptr_q;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic                    abort_q;

  logic [NREQ-1:0]         pick_gnt;
  logic [IDX_BITS-1:0]     pick_idx;
  logic                    pick_valid;

  logic                    locked;
  logic                    req_g;
  logic                    last_g;
  logic                    accept;
  logic                    wd_expire;
  logic [DATA_BITS-1:0]    dat_g;

  sia_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // gnt_q is one-hot while locked and zero when idle, so it doubles as the
  // select for the holder's request, last flag and data slice.
  always_comb begin
    dat_g = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) begin
        dat_g = dat_i[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign req_g     = |(req_i & gnt_q);
  assign last_g    = |(last_i & gnt_q);
  assign accept    = locked & req_g & txq_not_full_i;
  assign wd_expire = WD_EN && (wd_q == WD_LAST);

  assign ack_o     = {NREQ{accept}} & gnt_q;
  assign txq_we_o  = accept;
  assign txq_dat_o = dat_g;
  assign gnt_o     = gnt_q;
  assign abort_o   = abort_q;
  assign busy_o    = locked;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_RST;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_LOCKED;
            gnt_q   <= pick_gnt;
            ptr_q   <= pick_idx;
            wd_q    <= '0;
          end
        end
        ST_LOCKED: begin
          if (accept && last_g) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            wd_q    <= '0;
          end else if (req_g) begin
            // Holder still presenting a word (possibly back-pressured): not stalled.
            wd_q <= '0;
          end else if (wd_expire) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            wd_q    <= '0;
            abort_q <= 1'b1;
          end else if (WD_EN && (wd_q != '1)) begin
            wd_q <= wd_q + TIMEOUT_BITS'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sia_txarb.sv
// Self-checking bench for sia_txarb: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a packet-level reference model.
module tb_sia_txarb;

  localparam int NREQ = 4;
  localparam int DB   = 16;
  localparam int TOB  = 8;
  localparam int TO   = 10;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ-1:0]      last_i = '0;
  logic [NREQ*DB-1:0]   dat_i = '0;
  logic                 txq_not_full_i = 1'b1;
  logic [NREQ-1:0]      ack_o, gnt_o;
  logic [DB-1:0]        txq_dat_o;
  logic                 txq_we_o, abort_o, busy_o;

  always #5 clk = ~clk;

  sia_txarb #(
    .NREQ         (NREQ),
    .DATA_BITS    (DB),
    .TIMEOUT_BITS (TOB),
    .TIMEOUT      (TO)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_i          (req_i),
    .last_i         (last_i),
    .dat_i          (dat_i),
    .ack_o          (ack_o),
    .gnt_o          (gnt_o),
    .txq_dat_o      (txq_dat_o),
    .txq_we_o       (txq_we_o),
    .txq_not_full_i (txq_not_full_i),
    .abort_o        (abort_o),
    .busy_o         (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Traffic sources: words left in the current packet, forced-silence timer, current word.
  int            len[NREQ];
  int            mute_cnt[NREQ];
  logic [DB-1:0] word[NREQ];
  int            pushes[NREQ];
  int            push_log[$];

  // Reference model: who owns the queue (-1 = nobody), last winner, idle count.
  int   m_owner = -1;
  int   m_last  = NREQ - 1;
  int   m_idle  = 0;
  logic m_abort = 1'b0;
  int   nx_owner, nx_last, nx_idle;
  logic nx_abort;

  logic [NREQ-1:0] e_gnt, e_ack;
  logic            e_we, e_busy, e_abort;
  logic [DB-1:0]   e_dat;

  always_comb begin
    e_gnt = '0;
    e_dat = '0;
    e_we  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (k == m_owner) begin
        e_gnt[k] = 1'b1;
        e_dat    = dat_i[k*DB +: DB];
        e_we     = req_i[k] & txq_not_full_i;
      end
    end
    e_ack   = e_we ? e_gnt : '0;
    e_busy  = (m_owner >= 0);
    e_abort = m_abort;

    nx_owner = m_owner;
    nx_last  = m_last;
    nx_idle  = m_idle;
    nx_abort = 1'b0;
    if (m_owner < 0) begin
      for (int s = 1; s <= NREQ; s++) begin
        if (nx_owner < 0 && req_i[(m_last + s) % NREQ]) begin
          nx_owner = (m_last + s) % NREQ;
          nx_last  = nx_owner;
          nx_idle  = 0;
        end
      end
    end else if (e_we) begin
      nx_idle = 0;
      if (last_i[m_owner]) nx_owner = -1;
    end else if (req_i[m_owner]) begin
      nx_idle = 0;
    end else begin
      nx_idle = m_idle + 1;
      if (nx_idle >= TO) begin
        nx_abort = 1'b1;
        nx_owner = -1;
        nx_idle  = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_i) begin
      m_owner <= -1;
      m_last  <= NREQ - 1;
      m_idle  <= 0;
      m_abort <= 1'b0;
    end else begin
      m_owner <= nx_owner;
      m_last  <= nx_last;
      m_idle  <= nx_idle;
      m_abort <= nx_abort;
    end
  end

  // Per-cycle snapshot taken at the falling edge.
  logic [NREQ-1:0] o_gnt, o_ack;
  logic            o_we, o_abort, o_busy;
  logic [DB-1:0]   o_dat;
  logic [26:0]     o_vec, e_vec;

  // Drive sources, sample at negedge, consume acks, advance to just after posedge.
  task automatic tick();
    for (int k = 0; k < NREQ; k++) begin
      req_i[k]          = (len[k] > 0) && (mute_cnt[k] == 0);
      last_i[k]         = (len[k] == 1);
      dat_i[k*DB +: DB] = word[k];
    end
    @(negedge clk);
    o_gnt   = gnt_o;
    o_ack   = ack_o;
    o_we    = txq_we_o;
    o_abort = abort_o;
    o_busy  = busy_o;
    o_dat   = txq_dat_o;
    o_vec   = {o_gnt, o_ack, o_we, o_abort, o_busy, (o_we ? o_dat : 16'h0)};
    e_vec   = {e_gnt, e_ack, e_we, e_abort, e_busy, (e_we ? e_dat : 16'h0)};
    for (int k = 0; k < NREQ; k++) begin
      if (ack_o[k]) begin
        len[k]--;
        pushes[k]++;
        push_log.push_back(k);
        word[k] = DB'($urandom);
      end
      if (mute_cnt[k] > 0) mute_cnt[k]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < NREQ; k++) begin
      len[k]      = 0;
      mute_cnt[k] = 0;
      pushes[k]   = 0;
      word[k]     = DB'($urandom);
    end
    req_i          = '0;
    last_i         = '0;
    txq_not_full_i = 1'b1;
    reset_i        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    push_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NREQ; k++) len[k] = 1;
    reset_i = 1'b1;
    tick();
    n_checks++;
    if ({o_gnt, o_ack, o_we, o_abort, o_busy} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b ack=%b we=%b abort=%b busy=%b, required all zero",
               o_gnt, o_ack, o_we, o_abort, o_busy);
    end
    reset_i = 1'b0;
    tick();
    n_checks++;
    if (o_gnt !== 4'b0000 || o_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_arb_bubble: gnt=%b we=%b, required gnt=0000 we=0", o_gnt, o_we);
    end
    tick();
    n_checks++;
    if (o_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_priority: gnt=%b, required 0001", o_gnt);
    end
  endtask

  task automatic test_two_packets();
    logic [NREQ-1:0] g[8];
    do_reset();
    len[1] = 2;
    len[2] = 2;
    for (int c = 0; c < 8; c++) begin
      tick();
      g[c] = o_gnt;
      n_checks++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("FAIL two_packets_model c=%0d: got %h required %h", c, o_vec, e_vec);
      end
    end
    n_checks++;
    if ({g[1], g[2], g[3], g[4]} !== 16'b0010_0010_0000_0100) begin
      n_fail++;
      $display("FAIL two_packets_gnt_seq: got %b %b %b %b required 0010 0010 0000 0100",
               g[1], g[2], g[3], g[4]);
    end
    n_checks++;
    if (push_log.size() != 4 || push_log[0] != 1 || push_log[1] != 1 ||
        push_log[2] != 2 || push_log[3] != 2) begin
      n_fail++;
      $display("FAIL two_packets_order: got %0d pushes %p required 1,1,2,2", push_log.size(), push_log);
    end
  endtask

  task automatic test_rotate();
    int cycles = 0;
    do_reset();
    for (int k = 0; k < NREQ; k++) len[k] = 1;
    while (push_log.size() < 8 && cycles < 40) begin
      tick();
      cycles++;
      n_checks++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("FAIL rotate_model c=%0d: got %h required %h", cycles, o_vec, e_vec);
      end
      for (int k = 0; k < NREQ; k++) if (len[k] == 0) len[k] = 1;
    end
    n_checks++;
    if (push_log.size() < 8) begin
      n_fail++;
      $display("FAIL rotate_progress: got %0d pushes in 40 cycles, required 8", push_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (push_log[i] != i % NREQ) begin
          n_fail++;
          $display("FAIL rotate_order[%0d]: got requester %0d required %0d", i, push_log[i], i % NREQ);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DB-1:0] w0;
    do_reset();
    len[0] = 3;
    txq_not_full_i = 1'b0;
    tick();
    for (int c = 0; c < 50; c++) begin
      tick();
      n_checks++;
      if (o_ack !== 4'b0 || o_we !== 1'b0 || o_abort !== 1'b0 || o_gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL backpressure_hold c=%0d: ack=%b we=%b abort=%b gnt=%b required 0000 0 0 0001",
                 c, o_ack, o_we, o_abort, o_gnt);
      end
    end
    txq_not_full_i = 1'b1;
    w0 = word[0];
    tick();
    n_checks++;
    if (o_ack !== 4'b0001 || o_we !== 1'b1 || o_dat !== w0) begin
      n_fail++;
      $display("FAIL backpressure_release: ack=%b we=%b dat=%h required 0001 1 %h", o_ack, o_we, o_dat, w0);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("FAIL backpressure_model c=%0d: got %h required %h", c, o_vec, e_vec);
      end
    end
  endtask

  task automatic test_timeout();
    int  idle = 0;
    bit  stop = 0;
    do_reset();
    len[3] = 5;
    tick();
    tick();
    n_checks++;
    if (o_ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL timeout_first_word: ack=%b required 1000", o_ack);
    end
    mute_cnt[3] = 1000;
    len[0]      = 1;
    for (int c = 0; c < 40 && !stop; c++) begin
      tick();
      n_checks++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("FAIL timeout_model c=%0d: got %h required %h", c, o_vec, e_vec);
      end
      if (o_gnt === 4'b1000 && o_abort === 1'b0) idle++;
      else stop = 1;
    end
    n_checks++;
    if (idle != TO || o_abort !== 1'b1 || o_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_abort: idle cycles=%0d abort=%b gnt=%b required %0d 1 0000",
               idle, o_abort, o_gnt, TO);
    end
    tick();
    n_checks++;
    if (o_gnt !== 4'b0001 || o_abort !== 1'b0 || o_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_next_grant: gnt=%b abort=%b ack=%b required 0001 0 0001", o_gnt, o_abort, o_ack);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    len[2] = 4;
    tick();
    tick();
    n_checks++;
    if (o_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_mid_word1: ack=%b required 0100", o_ack);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    len[2] = 0;
    len[1] = 1;
    len[3] = 1;
    tick();
    n_checks++;
    if (o_gnt !== 4'b0000 || o_we !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: gnt=%b we=%b busy=%b required 0000 0 0", o_gnt, o_we, o_busy);
    end
    tick();
    n_checks++;
    if (o_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_priority: gnt=%b required 0010", o_gnt);
    end
  endtask

  task automatic test_single_word();
    bit saw_abort = 0;
    logic [NREQ-1:0] g1, g2;
    logic            we1;
    do_reset();
    len[2] = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 1) begin g1 = o_gnt; we1 = o_we; end
      if (c == 2) g2 = o_gnt;
      if (o_abort) saw_abort = 1;
    end
    n_checks++;
    if (g1 !== 4'b0100 || we1 !== 1'b1 || g2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_word_timing: gnt1=%b we1=%b gnt2=%b required 0100 1 0000", g1, we1, g2);
    end
    n_checks++;
    if (push_log.size() != 1 || pushes[2] != 1 || saw_abort) begin
      n_fail++;
      $display("FAIL single_word_count: pushes=%0d abort_seen=%0d required 1 0", push_log.size(), saw_abort);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (len[k] == 0 && $urandom_range(3, 0) == 0) len[k] = 1 + $urandom_range(3, 0);
        if (mute_cnt[k] == 0 && $urandom_range(39, 0) == 0) mute_cnt[k] = 3 + $urandom_range(14, 0);
      end
      txq_not_full_i = ($urandom_range(4, 0) != 0);
      reset_i        = ($urandom_range(299, 0) == 0);
      tick();
      n_checks++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got %h required %h", c, o_vec, e_vec);
      end
    end
    reset_i = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_two_packets();
    test_rotate();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_single_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
